m216a_pe_param: RTL and testbench

Parametrised successor to the M216A processing element. It runs one of eight instruction-selected arithmetic and stream functions on three unsigned input lanes and produces one result lane. Compared with the fixed 16-bit element it adds configurable data and accumulator widths, a configurable F6 coefficient, valid-qualified input and output, an optional saturation mode, and an automatic pipeline flush when the instruction changes. It sits in the same datapath slot as M216A_TopModule.

---
 rtl/m216a_pe_pkg.sv | 33 +++
 rtl/m216a_pe_delay_line.sv | 34 +++
 rtl/m216a_pe_param.sv | 134 +++++++++++++
 tb/tb_m216a_pe_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/m216a_pe_pkg.sv
// Shared opcodes, latency table and saturation helper for the M216A processing element.
package m216a_pe_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_F1  = 4'd1;
  localparam logic [3:0] OP_F2  = 4'd2;
  localparam logic [3:0] OP_F3  = 4'd3;
  localparam logic [3:0] OP_F4  = 4'd4;
  localparam logic [3:0] OP_F5  = 4'd5;
  localparam logic [3:0] OP_F6  = 4'd6;
  localparam logic [3:0] OP_F7  = 4'd7;
  localparam logic [3:0] OP_F8  = 4'd8;

  localparam int unsigned MAX_LAT = 6;
  // Width of the common container used for overflow detection.
  localparam int unsigned WIDE_W  = 128;

  // Cycles from sample acceptance to visible result; 0 means no result at all.
  function automatic logic [2:0] latency_of(input logic [3:0] op);
    case (op)
      OP_F1, OP_F3, OP_F4, OP_F5, OP_F6: return 3'd2;
      OP_F2, OP_F7:                      return 3'd4;
      OP_F8:                             return 3'd6;
      default:                           return 3'd0;
    endcase
  endfunction

  // True when v does not fit in w unsigned bits, i.e. a clamp is required.
  function automatic logic exceeds(input logic [WIDE_W-1:0] v, input int unsigned w);
    return (v >> w) != '0;
  endfunction

endpackage

// File: rtl/m216a_pe_delay_line.sv
// Valid-qualified shift register; every stage is exposed so the owner can pick a tap.
module m216a_pe_delay_line #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         valid_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [DEPTH-1:0]             valid_o,
  output logic [DEPTH-1:0][WIDTH-1:0]  data_o
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;

  // Valid chain: a clear kills everything in flight, but the incoming sample still enters stage 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses <= so every stage samples its neighbour's pre-edge value.
    if (rst_i) valid_q <= '0;
    else       valid_q <= {valid_q[DEPTH-2:0] & {(DEPTH-1){~clear_i}}, valid_i};
  end

  // Data chain: shifts unconditionally.
  // NOTE: the data stages have no reset; they are only observed through their valid bits.
  always_ff @(posedge clk_i) begin
    data_q <= {data_q[DEPTH-2:0], data_i};
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/m216a_pe_param.sv
// Parametrised M216A processing element: eight opcode-selected functions, valid-qualified
// stream, optional saturation, automatic flush on opcode change.
module m216a_pe_param
  import m216a_pe_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned F6_COEF = 7
) (
  input  logic               Clk_In,
  input  logic               Rst_In,
  input  logic [INSTR_W-1:0] Instruction_In,
  input  logic               In_Valid,
  input  logic               Sat_En,
  input  logic [DATA_W-1:0]  D_In1,
  input  logic [DATA_W-1:0]  D_In2,
  input  logic [DATA_W-1:0]  D_In3,
  output logic [DATA_W-1:0]  D_Out,
  output logic               Out_Valid
);

  localparam int unsigned RES_W = 2 * DATA_W + 1;
  localparam int unsigned SUM_W = ((ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W) + 1;
  localparam logic [DATA_W-1:0] DATA_MAX = '1;
  localparam logic [ACC_W-1:0]  ACC_MAX  = '1;

  logic [3:0]        op_d, op_q;
  logic              flush, accept;
  logic [DATA_W-1:0] hist1_q, hist1_d, hist2_q, hist2_d, h1_eff, h2_eff;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_eff, acc_new;
  logic [RES_W-1:0]  x1, x2, x3, p1, p2, prod_acc;
  logic [SUM_W-1:0]  acc_sum;
  logic [WIDE_W-1:0] wide_val;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] dout_q;

  logic [MAX_LAT-1:0]             dl_valid;
  logic [MAX_LAT-1:0][DATA_W-1:0] dl_data;
  logic [2:0]                     lat, tap_idx;

  generate
    if (INSTR_W > 4) begin : g_instr_hi
      logic unused_instr_hi;
      assign unused_instr_hi = ^Instruction_In[INSTR_W-1:4];
    end
  endgenerate

  // Decode: anything outside F1..F8 is a NOP.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no latch is inferred.
    op_d = OP_NOP;
    if (Instruction_In[3:0] >= OP_F1 && Instruction_In[3:0] <= OP_F8) op_d = Instruction_In[3:0];
  end

  assign flush   = (op_d != op_q);
  assign accept  = In_Valid && (op_d != OP_NOP);
  // A flush wipes history and acc before the new sample uses them.
  assign h1_eff  = flush ? '0 : hist1_q;
  assign h2_eff  = flush ? '0 : hist2_q;
  assign acc_eff = flush ? '0 : acc_q;

  // Datapath: full-width products, one carry bit on sums, then wrap or clamp.
  always_comb begin
    x1 = RES_W'(D_In1);
    x2 = RES_W'(D_In2);
    x3 = RES_W'(D_In3);
    p1 = RES_W'(h1_eff);
    p2 = RES_W'(h2_eff);
    prod_acc = (op_d == OP_F8) ? p1 * x1 : x3 * RES_W'(F6_COEF);
    acc_sum  = SUM_W'(acc_eff) + SUM_W'(prod_acc);
    acc_new  = (Sat_En && exceeds(WIDE_W'(acc_sum), ACC_W)) ? ACC_MAX : acc_sum[ACC_W-1:0];
    case (op_d)
      OP_F1, OP_F2: wide_val = WIDE_W'(x1);
      OP_F3:        wide_val = WIDE_W'(x2 + x3);
      OP_F4:        wide_val = WIDE_W'(x1 * x2);
      OP_F5:        wide_val = WIDE_W'(x1 + x2 * x3);
      OP_F7:        wide_val = WIDE_W'(p2 * p1 + x1);
      OP_F6, OP_F8: wide_val = WIDE_W'(acc_new);
      default:      wide_val = '0;
    endcase
    res = (Sat_En && exceeds(wide_val, DATA_W)) ? DATA_MAX : wide_val[DATA_W-1:0];

    acc_d   = acc_eff;
    hist1_d = h1_eff;
    hist2_d = h2_eff;
    if (accept) begin
      hist1_d = D_In1;
      hist2_d = h1_eff;
      if (op_d == OP_F6 || op_d == OP_F8) acc_d = acc_new;
    end
  end

  // Opcode, history and accumulator registers.
  always_ff @(posedge Clk_In or posedge Rst_In) begin
    if (Rst_In) begin
      op_q    <= OP_NOP;
      hist1_q <= '0;
      hist2_q <= '0;
      acc_q   <= '0;
    end else begin
      op_q    <= op_d;
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      acc_q   <= acc_d;
    end
  end

  m216a_pe_delay_line #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_LAT)
  ) u_delay (
    .clk_i   (Clk_In),
    .rst_i   (Rst_In),
    .clear_i (flush),
    .valid_i (accept),
    .data_i  (res),
    .valid_o (dl_valid),
    .data_o  (dl_data)
  );

  // Tap selection follows the registered opcode, which every in-flight sample shares.
  assign lat       = latency_of(op_q);
  assign tap_idx   = (lat == 3'd0) ? 3'd0 : lat - 3'd1;
  assign Out_Valid = (lat != 3'd0) && dl_valid[tap_idx];
  assign D_Out     = Out_Valid ? dl_data[tap_idx] : dout_q;

  // Hold register keeps the last result visible while Out_Valid is low.
  always_ff @(posedge Clk_In or posedge Rst_In) begin
    if (Rst_In)         dout_q <= '0;
    else if (Out_Valid) dout_q <= dl_data[tap_idx];
  end

endmodule

// File: tb/tb_m216a_pe_param.sv
// Directed self-checking bench for m216a_pe_param (16-bit default instance plus an 8-bit one).
module tb_m216a_pe_param;

  logic        Clk_In = 1'b0;
  logic        Rst_In;
  logic [15:0] Instruction_In;
  logic        In_Valid, Sat_En;
  logic [15:0] D_In1, D_In2, D_In3, D_Out;
  logic        Out_Valid;
  logic [7:0]  d8_1, d8_2, d8_3, d8_out;
  logic        v8_out;

  int tests = 0;
  int failed = 0;
  int last_exp = 0;
  int exp_a[0:10];

  always #5 Clk_In = ~Clk_In;

  m216a_pe_param u_dut (
    .Clk_In(Clk_In), .Rst_In(Rst_In), .Instruction_In(Instruction_In), .In_Valid(In_Valid),
    .Sat_En(Sat_En), .D_In1(D_In1), .D_In2(D_In2), .D_In3(D_In3), .D_Out(D_Out), .Out_Valid(Out_Valid)
  );

  m216a_pe_param #(.DATA_W(8)) u_dut8 (
    .Clk_In(Clk_In), .Rst_In(Rst_In), .Instruction_In(Instruction_In), .In_Valid(In_Valid),
    .Sat_En(Sat_En), .D_In1(d8_1), .D_In2(d8_2), .D_In3(d8_3), .D_Out(d8_out), .Out_Valid(v8_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  // Streams samples i=1..n (D_In1=i, D_In2=i+3, D_In3=i+7) with an optional gap,
  // then checks Out_Valid/D_Out every cycle against exp_a and the expected latency.
  task automatic run_stream(input logic [3:0] op, input int lat, input int n,
                            input int gap_at, input int gap_len, input string tag);
    int sent = 0;
    int got = 0;
    int gap_left = gap_len;
    int total = n + gap_len + lat + 2;
    bit acc_at[64];
    for (int c = 0; c < total; c++) begin
      Instruction_In = {12'h000, op};
      if (sent < n && !(sent == gap_at && gap_left > 0)) begin
        In_Valid = 1'b1;
        D_In1 = 16'(sent + 1);
        D_In2 = 16'(sent + 4);
        D_In3 = 16'(sent + 8);
        sent++;
        acc_at[c] = 1'b1;
      end else begin
        In_Valid = 1'b0;
        if (sent == gap_at && gap_left > 0) gap_left--;
        acc_at[c] = 1'b0;
      end
      tick();
      if (c >= lat - 1 && acc_at[c - lat + 1]) begin
        check($sformatf("%s_valid[%0d]", tag, c), 32'(Out_Valid), 32'd1);
        check($sformatf("%s_data[%0d]", tag, got), 32'(D_Out), 32'(exp_a[got]));
        last_exp = exp_a[got];
        got++;
      end else begin
        check($sformatf("%s_idle_valid[%0d]", tag, c), 32'(Out_Valid), 32'd0);
        check($sformatf("%s_hold[%0d]", tag, c), 32'(D_Out), 32'(last_exp));
      end
    end
    In_Valid = 1'b0;
  endtask

  initial begin
    Rst_In = 1'b1;
    Instruction_In = 16'h0000;
    In_Valid = 1'b0;
    Sat_En = 1'b0;
    D_In1 = '0; D_In2 = '0; D_In3 = '0;
    d8_1 = '0; d8_2 = '0; d8_3 = '0;
    tick();
    tick();
    check("reset_dout", 32'(D_Out), 32'd0);
    check("reset_valid", 32'(Out_Valid), 32'd0);
    @(negedge Clk_In);
    Rst_In = 1'b0;

    // Basic functions, In_Valid held high.
    exp_a = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    run_stream(4'd1, 2, 11, -1, 0, "f1");
    run_stream(4'd2, 4, 11, -1, 0, "f2");
    exp_a = '{33, 47, 63, 81, 0, 0, 0, 0, 0, 0, 0};
    run_stream(4'd5, 2, 4, -1, 0, "f5");
    exp_a = '{56, 119, 189, 266, 0, 0, 0, 0, 0, 0, 0};
    run_stream(4'd6, 2, 4, -1, 0, "f6");

    // Stream functions with a 3-cycle In_Valid gap after the 5th sample.
    exp_a = '{1, 2, 5, 10, 17, 26, 37, 50, 65, 82, 101};
    run_stream(4'd7, 4, 11, 5, 3, "f7");
    exp_a = '{0, 2, 8, 20, 40, 70, 112, 168, 240, 330, 440};
    run_stream(4'd8, 6, 11, 5, 3, "f8");

    // Flush: one F6 sample in flight when the opcode switches to F3 (upper bits ignored).
    Instruction_In = 16'h0006; In_Valid = 1'b1; D_In3 = 16'd10;
    tick();
    check("flush_f6_pending_valid", 32'(Out_Valid), 32'd0);
    check("flush_f6_pending_hold", 32'(D_Out), 32'd440);
    Instruction_In = 16'hF003; D_In2 = 16'd5; D_In3 = 16'd6;
    tick();
    check("flush_no_stale_valid", 32'(Out_Valid), 32'd0);
    check("flush_no_stale_hold", 32'(D_Out), 32'd440);
    In_Valid = 1'b0;
    tick();
    check("flush_f3_valid", 32'(Out_Valid), 32'd1);
    check("flush_f3_data", 32'(D_Out), 32'd11);
    tick();
    check("flush_f3_after_valid", 32'(Out_Valid), 32'd0);
    check("flush_f3_after_hold", 32'(D_Out), 32'd11);
    Instruction_In = 16'h0006; In_Valid = 1'b1; D_In3 = 16'd1;
    tick();
    check("f6_restart_pending", 32'(Out_Valid), 32'd0);
    In_Valid = 1'b0;
    tick();
    check("f6_restart_valid", 32'(Out_Valid), 32'd1);
    check("f6_restart_acc", 32'(D_Out), 32'd7);

    // Saturation on the 8-bit instance: 20*20 = 400 wraps to 144 or clamps to 255.
    Instruction_In = 16'h0004; In_Valid = 1'b1; d8_1 = 8'd20; d8_2 = 8'd20; Sat_En = 1'b0;
    tick();
    Sat_En = 1'b1;
    tick();
    check("sat8_wrap_valid", 32'(v8_out), 32'd1);
    check("sat8_wrap", 32'(d8_out), 32'd144);
    Sat_En = 1'b0;
    tick();
    check("sat8_clamp", 32'(d8_out), 32'd255);
    In_Valid = 1'b0;
    tick();
    check("sat8_wrap_again", 32'(d8_out), 32'd144);
    tick();
    check("sat8_idle_valid", 32'(v8_out), 32'd0);
    check("sat8_idle_hold", 32'(d8_out), 32'd144);

    // Asynchronous reset in the middle of an F8 stream.
    Instruction_In = 16'h0008;
    for (int i = 1; i <= 7; i++) begin
      In_Valid = 1'b1; D_In1 = 16'(i);
      tick();
    end
    In_Valid = 1'b0;
    check("f8_prereset_valid", 32'(Out_Valid), 32'd1);
    check("f8_prereset_data", 32'(D_Out), 32'd2);
    #2;
    Rst_In = 1'b1;
    #1;
    check("async_rst_dout", 32'(D_Out), 32'd0);
    check("async_rst_valid", 32'(Out_Valid), 32'd0);
    @(negedge Clk_In);
    Rst_In = 1'b0;
    In_Valid = 1'b1; D_In1 = 16'd3;
    tick();
    D_In1 = 16'd4;
    for (int c = 1; c <= 6; c++) begin
      tick();
      In_Valid = 1'b0;
      if (c < 5) check($sformatf("postrst_wait_valid[%0d]", c), 32'(Out_Valid), 32'd0);
    end
    check("postrst_second_valid", 32'(Out_Valid), 32'd1);
    check("postrst_second_data", 32'(D_Out), 32'd12);

    // Invalid opcode 12: samples dropped, D_Out holds.
    Instruction_In = 16'h000C; In_Valid = 1'b1; D_In1 = 16'd9; D_In2 = 16'd9; D_In3 = 16'd9;
    for (int c = 0; c < 7; c++) begin
      tick();
      check($sformatf("nop_valid[%0d]", c), 32'(Out_Valid), 32'd0);
      check($sformatf("nop_hold[%0d]", c), 32'(D_Out), 32'd12);
    end
    In_Valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
